// File: rtl/exp_iter.sv
// Iterative fixed-point e^x using a truncated Taylor series.
// The block runs one multiply per cycle, alternating term*x and *1/k, and saturates on large inputs.
module exp_iter #(
  parameter int unsigned                  DATA_WIDTH = 32,
  parameter int unsigned                  FRAC_BITS  = 16,
  parameter int unsigned                  TERMS      = 8,
  parameter logic signed [DATA_WIDTH-1:0] X_MAX      = 32'h000A65AF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] x,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  ack,
  output logic                  ovf,
  output logic                  unf
);

  localparam int unsigned PW = 2*DATA_WIDTH + 1;
  localparam int unsigned SW = DATA_WIDTH + 2;
  localparam int unsigned KW = $clog2(TERMS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULX = 2'd1;
  localparam logic [1:0] MULR = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic signed [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1) << FRAC_BITS;
  localparam logic signed [PW-1:0]         RND  = PW'(1) << (FRAC_BITS - 1);
  localparam logic signed [PW-1:0]         PMAX = (PW'(1) << (DATA_WIDTH - 1)) - PW'(1);
  localparam logic signed [PW-1:0]         PMIN = -PMAX - PW'(1);

  function automatic logic [DATA_WIDTH-1:0] recip_val(input int unsigned kv);
    logic [63:0] q;
    if (kv == 0) return '0;
    q = ((64'd1 << (FRAC_BITS + 1)) / 64'(kv) + 64'd1) >> 1;
    return q[DATA_WIDTH-1:0];
  endfunction

  // Full-width signed product, rounded half up, saturated back to DATA_WIDTH.
  function automatic logic signed [DATA_WIDTH-1:0] fxmul(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    p = (p + RND) >>> FRAC_BITS;
    if (p > PMAX)      fxmul = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (p < PMIN) fxmul = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else               fxmul = p[DATA_WIDTH-1:0];
  endfunction

  logic signed [DATA_WIDTH-1:0] recip [2**KW];

  for (genvar g = 0; g < 2**KW; g++) begin : g_recip
    assign recip[g] = (g >= 1 && g < TERMS) ? recip_val(g) : '0;
  end

  logic [1:0]                   state;
  logic [KW-1:0]                k;
  logic signed [DATA_WIDTH-1:0] xr;
  logic signed [DATA_WIDTH-1:0] term;
  logic signed [DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0] tnew;
  logic signed [SW-1:0]         sum;
  logic signed [SW-1:0]         sum_nxt;
  logic signed [SW:0]           acc;
  logic                         sat;

  assign ready = (state == IDLE);

  // Accumulator saturates rather than wrapping when a term would push it out of range.
  always_comb begin
    tnew = fxmul(prod, recip[k]);
    acc  = (SW+1)'(sum) + (SW+1)'(tnew);
    if (acc[SW] != acc[SW-1])
      sum_nxt = acc[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
    else
      sum_nxt = acc[SW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      xr    <= '0;
      term  <= '0;
      prod  <= '0;
      sum   <= '0;
      sat   <= 1'b0;
      y     <= '0;
      ack   <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ($signed(x) > X_MAX) begin
              sat   <= 1'b1;
              state <= DONE;
            end else begin
              sat   <= 1'b0;
              xr    <= x;
              term  <= ONE;
              sum   <= SW'(ONE);
              k     <= KW'(1);
              state <= MULX;
            end
          end
        end
        MULX: begin
          prod  <= fxmul(term, xr);
          state <= MULR;
        end
        MULR: begin
          term  <= tnew;
          sum   <= sum_nxt;
          k     <= k + KW'(1);
          state <= (k == KW'(TERMS - 1)) ? DONE : MULX;
        end
        DONE: begin
          ack   <= 1'b1;
          state <= IDLE;
          if (sat || (!sum[SW-1] && sum[SW-2])) begin
            y   <= '1;
            ovf <= 1'b1;
            unf <= 1'b0;
          end else if (sum[SW-1]) begin
            y   <= '0;
            ovf <= 1'b0;
            unf <= 1'b1;
          end else begin
            y   <= sum[DATA_WIDTH-1:0];
            ovf <= 1'b0;
            unf <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
